// File: rtl/up_mem_dma_pkg.sv
// Shared definitions for the up_memory block-copy engine: default widths and FSM state encoding.
package up_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;
endpackage

// File: rtl/up_mem_dma_if.sv
// up_memory port as seen by the copy engine (master) and by the memory (slave).
interface up_mem_dma_if
  import up_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic          mem_we;
  logic [DW-1:0] mem_out;
  logic          mem_re;

  modport master (output mem_address, mem_in, mem_we, input mem_out, mem_re);
  modport slave  (input mem_address, mem_in, mem_we, output mem_out, mem_re);
endinterface

// File: rtl/up_mem_dma_agen.sv
// Offset and address generation; descending copies walk from the last byte back to the first.
module up_mem_dma_agen #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] idx,
  input  logic [AW-1:0] len,
  input  logic          dir,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] off;

  always_comb begin
    off  = dir ? (len - AW'(1) - idx) : idx;
    addr = base + off;
  end
endmodule

// File: rtl/up_mem_dma.sv
// Block-copy initiator: reads a byte, writes it, repeats for len bytes in either direction.
//   state | meaning
//   IDLE  | waiting for start, memory port released
//   RD    | source read on the bus, waits for mem_re
//   WR    | destination write of the latched byte
//   FIN   | one-cycle done pulse
module up_mem_dma
  import up_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic          dir,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  up_mem_dma_if.master  mem
);
  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] agen_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          if (len != '0) begin
            src_d   = src;
            dst_d   = dst;
            len_d   = len;
            dir_d   = dir;
            idx_d   = '0;
            state_d = RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      RD: begin
        // abort wins over a read that completes in the same cycle
        if (abort) begin
          state_d = FIN;
        end else if (mem.mem_re) begin
          data_d  = mem.mem_out;
          state_d = WR;
        end
      end
      WR: begin
        count_d = count_q + 1'b1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == len_q - AW'(1) || abort) state_d = FIN;
        else                                  state_d = RD;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  up_mem_dma_agen #(.AW(AW)) u_agen (
    .base (state_q == WR ? dst_q : src_q),
    .idx  (idx_q),
    .len  (len_q),
    .dir  (dir_q),
    .addr (agen_addr)
  );

  // Bus outputs decode registered state only, so no input reaches the memory combinationally.
  always_comb begin
    busy            = (state_q == RD) || (state_q == WR);
    done            = (state_q == FIN);
    count           = count_q;
    mem.mem_address = busy ? agen_addr : '0;
    mem.mem_in      = (state_q == WR) ? data_q : '0;
    mem.mem_we      = (state_q == WR);
  end
endmodule

// File: tb/tb_up_mem_dma.sv
// Directed bench for up_mem_dma with a behavioural 256-byte memory.
module tb_up_mem_dma;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src = '0, dst = '0, len = '0;
  logic       dir = 1'b0, abort = 1'b0;
  logic       busy, done;
  logic [8:0] count;
  logic       re = 1'b1;

  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;
  logic [7:0] rd_log[$];
  logic [7:0] wr_log[$];
  int         we_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  up_mem_dma_if mif ();
  assign mif.mem_out = mem[mif.mem_address];
  assign mif.mem_re  = re;

  up_mem_dma dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .dir(dir), .abort(abort), .busy(busy), .done(done), .count(count), .mem(mif.master)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mif.mem_we) begin
      mem[mif.mem_address] <= mif.mem_in;
      wr_log.push_back(mif.mem_address);
      we_cnt <= we_cnt + 1;
    end
    if (busy && !mif.mem_we && re && !abort) rd_log.push_back(mif.mem_address);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input logic dr);
    src = s; dst = d; len = l; dir = dr; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Cycle numbering: the cycle right after the start edge is cycle 1.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input logic dr, output int done_cyc, output int busy_cyc);
    kick(s, d, l, dr);
    done_cyc = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = k;
        break;
      end
      tick;
    end
    tick;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (count !== 9'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (mif.mem_we !== 1'b0 || mif.mem_address !== 8'h00 || mif.mem_in !== 8'h00) begin
      n_err++; $display("FAIL reset_bus: got we=%b addr=%h in=%h want 0/00/00", mif.mem_we, mif.mem_address, mif.mem_in);
    end
  endtask

  task automatic test_ascending;
    logic [7:0] exp [4];
    int dc, bc;
    exp[0] = 8'h02; exp[1] = 8'h80; exp[2] = 8'h16; exp[3] = 8'h80;
    for (int i = 0; i < 4; i++) poke(8'(i), exp[i]);
    run_copy(8'h00, 8'h80, 8'd4, 1'b0, dc, bc);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem[8'h80 + 8'(i)] !== exp[i]) begin
        n_err++; $display("FAIL asc_data[%0d]: got %h want %h", i, mem[8'h80 + 8'(i)], exp[i]);
      end
    end
    n_vec++; if (dc != 9) begin n_err++; $display("FAIL asc_done_cycle: got %0d want 9", dc); end
    n_vec++; if (bc != 8) begin n_err++; $display("FAIL asc_busy_cycles: got %0d want 8", bc); end
    n_vec++; if (count !== 9'd4) begin n_err++; $display("FAIL asc_count: got %0d want 4", count); end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_d [4];
    logic [7:0] exp_a [4];
    int dc, bc, rb;
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hA4;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    for (int i = 0; i < 4; i++) poke(exp_a[i], exp_d[i]);
    rb = rd_log.size();
    run_copy(8'hFE, 8'h40, 8'd4, 1'b0, dc, bc);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem[8'h40 + 8'(i)] !== exp_d[i]) begin
        n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, mem[8'h40 + 8'(i)], exp_d[i]);
      end
    end
    n_vec++;
    if (rd_log.size() != rb + 4) begin
      n_err++; $display("FAIL wrap_read_count: got %0d want 4", rd_log.size() - rb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rd_log[rb + i] !== exp_a[i]) begin
          n_err++; $display("FAIL wrap_read_addr[%0d]: got %h want %h", i, rd_log[rb + i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_desc_overlap;
    logic [7:0] exp_d [4];
    logic [7:0] exp_w [4];
    int dc, bc, wb;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    exp_w[0] = 8'h15; exp_w[1] = 8'h14; exp_w[2] = 8'h13; exp_w[3] = 8'h12;
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), exp_d[i]);
    wb = wr_log.size();
    run_copy(8'h10, 8'h12, 8'd4, 1'b1, dc, bc);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (mem[8'h12 + 8'(i)] !== exp_d[i]) begin
        n_err++; $display("FAIL desc_data[%0d]: got %h want %h", i, mem[8'h12 + 8'(i)], exp_d[i]);
      end
    end
    n_vec++;
    if (wr_log.size() != wb + 4) begin
      n_err++; $display("FAIL desc_write_count: got %0d want 4", wr_log.size() - wb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_log[wb + i] !== exp_w[i]) begin
          n_err++; $display("FAIL desc_write_addr[%0d]: got %h want %h", i, wr_log[wb + i], exp_w[i]);
        end
      end
    end
    n_vec++; if (dc != 9) begin n_err++; $display("FAIL desc_done_cycle: got %0d want 9", dc); end
  endtask

  task automatic test_len0_and_busy_start;
    int dc, bc, wc;
    bit seen_busy;
    wc = we_cnt;
    run_copy(8'h00, 8'h90, 8'd0, 1'b0, dc, bc);
    n_vec++; if (dc != 1) begin n_err++; $display("FAIL len0_done_cycle: got %0d want 1", dc); end
    n_vec++; if (count !== 9'd0) begin n_err++; $display("FAIL len0_count: got %0d want 0", count); end
    n_vec++; if (we_cnt != wc || bc != 0) begin
      n_err++; $display("FAIL len0_no_access: got writes=%0d busy=%0d want 0/0", we_cnt - wc, bc);
    end

    poke(8'h30, 8'h5A); poke(8'h31, 8'h5B); poke(8'h32, 8'h5C); poke(8'h70, 8'hEE);
    kick(8'h30, 8'h50, 8'd3, 1'b0);
    tick;
    src = 8'h31; dst = 8'h70; len = 8'd1; dir = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    dc = -1;
    for (int k = 3; k <= 100; k++) begin
      if (done) begin dc = k; break; end
      tick;
    end
    n_vec++; if (dc != 7) begin n_err++; $display("FAIL busy_start_done_cycle: got %0d want 7", dc); end
    n_vec++; if (count !== 9'd3) begin n_err++; $display("FAIL busy_start_count: got %0d want 3", count); end
    seen_busy = 1'b0;
    repeat (4) begin tick; if (busy) seen_busy = 1'b1; end
    n_vec++;
    if (mem[8'h50] !== 8'h5A || mem[8'h51] !== 8'h5B || mem[8'h52] !== 8'h5C || mem[8'h70] !== 8'hEE || seen_busy) begin
      n_err++; $display("FAIL busy_start_ignored: got %h %h %h dst70=%h rerun=%b want 5a 5b 5c ee 0",
                        mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h70], seen_busy);
    end
  endtask

  task automatic test_stall;
    logic [7:0] a0;
    int dc;
    bit moved;
    poke(8'h08, 8'hC1); poke(8'h09, 8'hC2);
    re = 1'b0;
    kick(8'h08, 8'hA0, 8'd2, 1'b0);
    a0 = mif.mem_address;
    moved = 1'b0;
    n_vec++; if (a0 !== 8'h08) begin n_err++; $display("FAIL stall_addr: got %h want 08", a0); end
    repeat (3) begin
      tick;
      if (mif.mem_address !== 8'h08 || mif.mem_we !== 1'b0) moved = 1'b1;
    end
    re = 1'b1;
    n_vec++; if (moved) begin n_err++; $display("FAIL stall_addr_stable: got moved=1 want 0"); end
    dc = -1;
    for (int k = 4; k <= 100; k++) begin
      if (done) begin dc = k; break; end
      tick;
    end
    n_vec++; if (dc != 8) begin n_err++; $display("FAIL stall_done_cycle: got %0d want 8", dc); end
    tick;
    n_vec++; if (mem[8'hA0] !== 8'hC1 || mem[8'hA1] !== 8'hC2) begin
      n_err++; $display("FAIL stall_data: got %h %h want c1 c2", mem[8'hA0], mem[8'hA1]);
    end
  endtask

  task automatic test_abort_reset;
    bit saw_done;
    for (int i = 0; i < 5; i++) begin
      poke(8'h20 + 8'(i), 8'(i + 1));
      poke(8'h60 + 8'(i), 8'hFF);
    end
    kick(8'h20, 8'h60, 8'd5, 1'b0);
    repeat (3) tick;
    abort = 1'b1;
    n_vec++; if (mif.mem_we !== 1'b1 || mif.mem_address !== 8'h61) begin
      n_err++; $display("FAIL abort_second_wr: got we=%b addr=%h want 1/61", mif.mem_we, mif.mem_address);
    end
    tick;
    abort = 1'b0;
    n_vec++; if (done !== 1'b1 || count !== 9'd2) begin
      n_err++; $display("FAIL abort_done_count: got done=%b count=%0d want 1/2", done, count);
    end
    tick;
    n_vec++; if (mem[8'h60] !== 8'h01 || mem[8'h61] !== 8'h02 || mem[8'h62] !== 8'hFF || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_mem: got %h %h %h busy=%b want 01 02 ff 0", mem[8'h60], mem[8'h61], mem[8'h62], busy);
    end

    poke(8'h25, 8'h77); poke(8'h26, 8'h78); poke(8'h68, 8'hFF); poke(8'h69, 8'hFF);
    kick(8'h25, 8'h68, 8'd2, 1'b0);
    tick; tick;
    rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 9'd0 || mif.mem_we !== 1'b0 ||
        mif.mem_address !== 8'h00 || mif.mem_in !== 8'h00) begin
      n_err++; $display("FAIL reset_mid_rd: got busy=%b done=%b count=%0d we=%b addr=%h in=%h want all 0",
                        busy, done, count, mif.mem_we, mif.mem_address, mif.mem_in);
    end
    tick;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (5) begin tick; if (done || busy) saw_done = 1'b1; end
    n_vec++; if (saw_done) begin n_err++; $display("FAIL reset_no_done: got activity=1 want 0"); end
    n_vec++; if (mem[8'h68] !== 8'h77 || mem[8'h69] !== 8'hFF) begin
      n_err++; $display("FAIL reset_mem: got %h %h want 77 ff", mem[8'h68], mem[8'h69]);
    end
  endtask

  initial begin
    test_reset;
    test_ascending;
    test_wrap;
    test_desc_overlap;
    test_len0_and_busy_start;
    test_stall;
    test_abort_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
